pulse_meter: RTL
================

# pulse_meter

Measures a pulse wave on a 16-bit signed sample stream and recovers its frequency control word and duty cycle control word, in the same 32-bit fixed-point encoding the pulse generator consumes. It sits on the analysis side of the synthesizer, closing the loop on generator output for self-test and calibration. It also serves any external two-level source presented on the same sample bus. Each completed period is turned into a new (ctrl, duty) pair by a pair of parallel sequential dividers.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sample  input  16  signed amplitude. The level is high when sample[15]==0 and low when sample[15]==1.
- ctrl  output  32  measured frequency word, floor(2^32 / P).
- duty  output  32  measured duty word, floor(H * 2^32 / P).
- valid  output  1  one-cycle strobe; ctrl and duty were updated this cycle.
- overrun  output  1  one-cycle strobe; a completed period was dropped because the divider was busy.

## Operation
- **Level pipeline:** lvl_r <= ~sample[15]; lvl_d <= lvl_r. A rise is a cycle in which lvl_r & ~lvl_d.
- **Counters** (32-bit, saturating at 0xFFFFFFFF):
  - per_cnt increments every cycle.
  - hi_cnt increments on cycles where lvl_r==1.
  - On a rise, both counters load 1.
- **Measurement:** on a rise, P=per_cnt and H=hi_cnt are the period and high time of the period just ended. Always 2 <= P and 1 <= H < P.
- **Arming FSM:**
  - States SYNC → RUN.
  - Reset enters SYNC.
  - The first rise in SYNC only clears the counters and moves to RUN; no measurement is issued.
  - In RUN, every rise produces a measurement.
- **Measurement disposition:**
  - Saturated: if per_cnt==0xFFFFFFFF at the rise, the measurement is discarded silently. There is no valid and no overrun; the counters restart.
  - Divider busy: the measurement is discarded and overrun pulses. The counters restart either way.
  - Divider idle: P and H are latched and the divider starts.
- **Divider FSM:** states D_IDLE → D_BUSY (32 iterations) → D_DONE (1 cycle) → D_IDLE.
  - Two restoring dividers run in lockstep with shared divisor P.
  - Remainder registers are 33-bit, initialised to 1 (ctrl path) and H (duty path).
  - Each iteration: rem = {rem,1'b0}. If rem >= P, then rem -= P and the quotient bit is 1, else 0. Quotient bits are shifted in MSB first.
  - After 32 iterations each quotient is exactly the floor values defined above. Neither can exceed 32 bits because the initial remainder is less than P.
  - In D_DONE, ctrl and duty load the quotients and valid=1.
- **Outputs:** ctrl and duty hold between updates.
- **Constant input:** no rise ever occurs, so outputs hold indefinitely.

## Timing
- **Reset:** while rst_n is low, every state element clears immediately. This includes lvl_r, lvl_d and both counters. The FSMs go to SYNC and D_IDLE.
  - Outputs during reset: ctrl=0, duty=0, valid=0, overrun=0.
  - Reset released mid-division: the division is abandoned, no valid is issued, and re-arming is required.
- **Input to rise:** a sample change at cycle n reaches lvl_r at n+1; the rise is evaluated in cycle n+1.
- **Rise to result:** for a rise in cycle r that starts the divider:
  - D_BUSY spans cycles r+1 .. r+32.
  - D_DONE is cycle r+33: valid=1, and ctrl/duty show the new values from r+33.
- **Busy window:** the divider is busy from r+1 through r+33 inclusive. A rise in that window is dropped, with overrun=1 in that same rise cycle.
- **Next acceptance:** a rise at r+34 or later is accepted.
- **Per-cycle limits:** valid is at most one cycle per accepted measurement. valid and overrun may assert in the same cycle (rise at r+33).
- **Throughput:** at most one result per 34 cycles.

## Test plan
- **Generator loop:** drive from the pulse generator with ctrl=0x40000000, duty=0x80000000. After the second rise, expect valid with ctrl=0x40000000, duty=0x80000000, repeating every 34–36 cycles, with no result after the first rise.
- **Directed waveform, period 8:** sample stream of 3 cycles 0x7FFF then 5 cycles 0x8001, repeated. Expect ctrl=0x20000000, duty=0x60000000. Check valid exactly 33 cycles after each accepted rise.
- **Rounding:** period 3, high 1. Expect ctrl=0x55555555, duty=0x55555555 (floor rounding).
- **Overrun:** period 2 (alternating 0x7FFF/0x8001).
  - Expect ctrl=0x80000000, duty=0x80000000.
  - Expect overrun pulses on every rise inside the busy window.
  - Expect no valid between accepted measurements.
- **Saturation:** hold low for 2^32 cycles (force per_cnt near 0xFFFFFFFF via a shortened bench hook if needed), then apply a rise. Expect no valid and no overrun; the next full period is measured correctly.
- **Reset mid-operation:**
  - Assert rst_n=0 during D_BUSY: ctrl=0, duty=0, valid=0 immediately.
  - After release, the first rise gives no valid; the second rise gives a correct result 33 cycles later.

Source files
------------

// File: rtl/pulse_meter_if.sv
// Sample bus into the pulse meter and the measured (ctrl, duty) result out of it.
// The meter attaches through the slave modport; the source side uses master.
interface pulse_meter_if;
  logic signed [15:0] sample;
  logic        [31:0] ctrl;
  logic        [31:0] duty;
  logic               valid;
  logic               overrun;

  modport master (output sample, input ctrl, duty, valid, overrun);
  modport slave  (input sample, output ctrl, duty, valid, overrun);
endinterface

// File: rtl/pulse_meter.sv
// Pulse-wave meter: times each period of a two-level sample stream and divides
// it into a frequency word floor(2^32/P) and a duty word floor(H*2^32/P).
module pulse_meter (
  input  logic          clk,
  input  logic          rst_n,
  pulse_meter_if.slave  bus
);
  typedef enum logic {SYNC, RUN} arm_t;
  typedef enum logic [1:0] {D_IDLE, D_BUSY, D_DONE} div_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic        lvl_r, lvl_d, rise;
  logic [31:0] per_cnt, hi_cnt;
  arm_t        arm_state, arm_next;
  div_t        div_state, div_next;
  logic        measure, start, last_iter;
  logic        valid_c, overrun_c;
  logic [4:0]  iter;
  logic [31:0] divisor, q_c, q_d, ctrl_r, duty_r;
  logic [32:0] rem_c, rem_d, sh_c, sh_d;
  logic        bit_c, bit_d;
  logic        sample_unused;

  // Only the sign bit carries the level; the magnitude is irrelevant here.
  assign sample_unused = ^bus.sample[14:0];

  assign rise      = lvl_r & ~lvl_d;
  assign measure   = rise && (arm_state == RUN) && (per_cnt != CNT_MAX);
  assign last_iter = (iter == 5'd31);

  // One restoring step per cycle; the remainder is always below the divisor,
  // so shifting the 33-bit register never loses a set bit.
  assign sh_c  = rem_c << 1;
  assign sh_d  = rem_d << 1;
  assign bit_c = (sh_c >= {1'b0, divisor});
  assign bit_d = (sh_d >= {1'b0, divisor});

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_r   <= 1'b0;
      lvl_d   <= 1'b0;
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      lvl_r <= ~bus.sample[15];
      lvl_d <= lvl_r;
      if (rise) begin
        per_cnt <= 32'd1;
        hi_cnt  <= 32'd1;
      end else begin
        if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 32'd1;
        if (lvl_r && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_state <= SYNC;
      div_state <= D_IDLE;
    end else begin
      arm_state <= arm_next;
      div_state <= div_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case/if structure can leave a value unassigned and infer a latch.
  always_comb begin
    arm_next  = arm_state;
    div_next  = div_state;
    start     = 1'b0;
    valid_c   = 1'b0;
    overrun_c = 1'b0;
    if ((arm_state == SYNC) && rise) arm_next = RUN;
    if (measure) begin
      if (div_state == D_IDLE) start = 1'b1;
      else                     overrun_c = 1'b1;
    end
    case (div_state)
      D_IDLE:  if (start) div_next = D_BUSY;
      D_BUSY:  if (last_iter) div_next = D_DONE;
      D_DONE: begin
        valid_c  = 1'b1;
        div_next = D_IDLE;
      end
      default: div_next = D_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, so the outputs read zero the
  // moment rst_n falls rather than after the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor <= '0;
      rem_c   <= '0;
      rem_d   <= '0;
      q_c     <= '0;
      q_d     <= '0;
      iter    <= '0;
      ctrl_r  <= '0;
      duty_r  <= '0;
    end else if (start) begin
      divisor <= per_cnt;
      rem_c   <= 33'd1;
      rem_d   <= {1'b0, hi_cnt};
      q_c     <= '0;
      q_d     <= '0;
      iter    <= '0;
    end else if (div_state == D_BUSY) begin
      rem_c <= bit_c ? (sh_c - {1'b0, divisor}) : sh_c;
      rem_d <= bit_d ? (sh_d - {1'b0, divisor}) : sh_d;
      q_c   <= {q_c[30:0], bit_c};
      q_d   <= {q_d[30:0], bit_d};
      iter  <= iter + 5'd1;
    end else if (div_state == D_DONE) begin
      ctrl_r <= q_c;
      duty_r <= q_d;
    end
  end

  // The fresh quotients bypass the holding registers during D_DONE so the new
  // values are visible in the same cycle as the valid strobe.
  assign bus.ctrl    = (div_state == D_DONE) ? q_c : ctrl_r;
  assign bus.duty    = (div_state == D_DONE) ? q_d : duty_r;
  assign bus.valid   = valid_c;
  assign bus.overrun = overrun_c;
endmodule
